// File: rtl/pbus_arb.sv
// Two-master round-robin arbiter for the peripheral bus with a per-transaction
// watchdog that turns hung or unmapped accesses into error responses.
module pbus_arb #(
  parameter int TIMEOUT     = 255,
  parameter int XLEN        = 32,
  parameter int BUS_WIDTH   = 32,
  parameter int BUS_ACC_CNT = 4,
  parameter int CW          = $clog2(TIMEOUT + 1),
  parameter int AW          = (BUS_ACC_CNT > 1) ? $clog2(BUS_ACC_CNT) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0_req,
  input  logic [XLEN-1:0]      m0_addr,
  input  logic                 m0_w_rb,
  input  logic [AW-1:0]        m0_acc,
  input  logic [BUS_WIDTH-1:0] m0_wdata,
  output logic                 m0_resp,
  output logic                 m0_err,
  output logic [BUS_WIDTH-1:0] m0_rdata,
  input  logic                 m1_req,
  input  logic [XLEN-1:0]      m1_addr,
  input  logic                 m1_w_rb,
  input  logic [AW-1:0]        m1_acc,
  input  logic [BUS_WIDTH-1:0] m1_wdata,
  output logic                 m1_resp,
  output logic                 m1_err,
  output logic [BUS_WIDTH-1:0] m1_rdata,
  output logic                 s_req,
  output logic [XLEN-1:0]      s_addr,
  output logic                 s_w_rb,
  output logic [AW-1:0]        s_acc,
  output logic [BUS_WIDTH-1:0] s_wdata,
  input  logic                 s_resp,
  input  logic [BUS_WIDTH-1:0] s_rdata,
  input  logic                 s_fault,
  output logic                 tmo_fault,
  output logic [XLEN-1:0]      tmo_addr
);

  localparam logic IDLE = 1'b0;
  localparam logic BUSY = 1'b1;

  logic            state_q, state_d;
  logic            grant_q, grant_d;
  logic            prio_q, prio_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] tmoAddr_q, tmoAddr_d;

  logic winner;
  logic sel;
  logic active;
  logic timeout;
  logic done;

  // Ties go to the preferred master; with no request the m0 fields are shown.
  assign winner  = m1_req & (~m0_req | prio_q);
  assign sel     = (state_q == BUSY) ? grant_q : winner;
  assign active  = (state_q == BUSY) | m0_req | m1_req;
  assign timeout = (state_q == BUSY) & (cnt_q == CW'(TIMEOUT)) & ~s_resp & ~s_fault;
  assign done    = active & (s_resp | s_fault | timeout);

  assign s_addr  = sel ? m1_addr  : m0_addr;
  assign s_w_rb  = sel ? m1_w_rb  : m0_w_rb;
  assign s_acc   = sel ? m1_acc   : m0_acc;
  assign s_wdata = sel ? m1_wdata : m0_wdata;

  // Outputs are held quiet while reset is asserted so an aborted master sees nothing.
  assign s_req     = active & ~timeout & ~rst;
  assign tmo_fault = timeout & ~rst;
  assign m0_resp   = done & ~sel & ~rst;
  assign m1_resp   = done & sel & ~rst;
  assign m0_err    = m0_resp & ~s_resp;
  assign m1_err    = m1_resp & ~s_resp;
  assign m0_rdata  = s_rdata;
  assign m1_rdata  = s_rdata;
  assign tmo_addr  = tmoAddr_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    tmoAddr_d = tmoAddr_q;
    if (state_q == IDLE) begin
      if (m0_req | m1_req) begin
        if (s_resp | s_fault) begin
          prio_d = ~winner;
        end else begin
          state_d = BUSY;
          grant_d = winner;
          cnt_d   = CW'(1);
        end
      end
    end else begin
      if (done) begin
        state_d = IDLE;
        prio_d  = ~grant_q;
        cnt_d   = '0;
        if (timeout) tmoAddr_d = s_addr;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
      cnt_q     <= '0;
      tmoAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
      cnt_q     <= cnt_d;
      tmoAddr_q <= tmoAddr_d;
    end
  end

endmodule
